// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the MIPS datapath.
// The master side is the sequencer; the slave side is the datapath and memory port.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_sel_data;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] npc_sel;
  logic       reg_write;
  logic       select_regWritten;
  logic       select_anotherAluSource;
  logic       ctrl_dataMem2reg;
  logic [1:0] select_aluPerformance;
  logic [2:0] state;
  logic       instr_retired;
  logic       err;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, mem_sel_data, ir_write, pc_write, npc_sel,
           reg_write, select_regWritten, select_anotherAluSource,
           ctrl_dataMem2reg, select_aluPerformance, state, instr_retired, err
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, mem_sel_data, ir_write, pc_write, npc_sel,
           reg_write, select_regWritten, select_anotherAluSource,
           ctrl_dataMem2reg, select_aluPerformance, state, instr_retired, err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory port,
// with a wait-state timeout that parks the machine in a sticky ERR state.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } class_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  class_e     dec_class;
  logic       mem_req, tmo_hit, enter_mem_phase;
  logic       mem_we, mem_sel, ir_write, pc_write, reg_write;
  logic       sel_rd, sel_imm, mem2reg, retired;
  logic [1:0] npc_sel, alu_op;

  function automatic class_e decode_class(logic [5:0] op, logic [5:0] fn);
    class_e c;
    case (op)
      6'h00:   c = (fn == 6'h21) ? C_ADDU : (fn == 6'h23) ? C_SUBU : C_ILL;
      6'h0D:   c = C_ORI;
      6'h0F:   c = C_LUI;
      6'h23:   c = C_LW;
      6'h2B:   c = C_SW;
      6'h04:   c = C_BEQ;
      6'h02:   c = C_J;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  // Returns {alu_op, b_is_imm}; held unchanged from EXEC through MEM and WB.
  function automatic logic [2:0] alu_ctrl(class_e c);
    logic [2:0] r;
    case (c)
      C_ADDU:     r = 3'b00_0;
      C_SUBU:     r = 3'b01_0;
      C_ORI:      r = 3'b10_1;
      C_LUI:      r = 3'b11_1;
      C_LW, C_SW: r = 3'b00_1;
      C_BEQ:      r = 3'b01_0;
      default:    r = 3'b00_0;
    endcase
    return r;
  endfunction

  assign dec_class = decode_class(bus.opcode, bus.funct);
  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmo_hit   = mem_req && !bus.mem_ready && (cnt_q >= TMO_LAST);

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    npc_sel   = 2'b00;
    reg_write = 1'b0;
    sel_rd    = 1'b0;
    sel_imm   = 1'b0;
    mem2reg   = 1'b0;
    alu_op    = 2'b00;
    retired   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        case (dec_class)
          C_J: begin
            pc_write = 1'b1;
            npc_sel  = 2'b10;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end
          C_ILL:   state_d = S_ERR;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        {alu_op, sel_imm} = alu_ctrl(class_q);
        case (class_q)
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW:                   state_d = S_MEM;
          C_BEQ: begin
            pc_write = bus.alu_zero;
            npc_sel  = bus.alu_zero ? 2'b01 : 2'b00;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        {alu_op, sel_imm} = alu_ctrl(class_q);
        mem_sel = 1'b1;
        mem_we  = (class_q == C_SW);
        if (bus.mem_ready) begin
          retired = (class_q == C_SW);
          state_d = (class_q == C_SW) ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        {alu_op, sel_imm} = alu_ctrl(class_q);
        reg_write = 1'b1;
        sel_rd    = (class_q == C_ADDU) || (class_q == C_SUBU);
        mem2reg   = (class_q == C_LW);
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Each new memory phase starts its wait budget from zero.
  assign enter_mem_phase = ((state_d == S_FETCH) && (state_q != S_FETCH)) ||
                           ((state_d == S_MEM)   && (state_q != S_MEM));

  always_comb begin
    cnt_d = cnt_q;
    if (enter_mem_phase || bus.mem_ready) begin
      cnt_d = '0;
    end else if (mem_req && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      class_q <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_req                 = mem_req;
  assign bus.mem_we                  = mem_we;
  assign bus.mem_sel_data            = mem_sel;
  assign bus.ir_write                = ir_write;
  assign bus.pc_write                = pc_write;
  assign bus.npc_sel                 = npc_sel;
  assign bus.reg_write               = reg_write;
  assign bus.select_regWritten       = sel_rd;
  assign bus.select_anotherAluSource = sel_imm;
  assign bus.ctrl_dataMem2reg        = mem2reg;
  assign bus.select_aluPerformance   = alu_op;
  assign bus.state                   = state_q;
  assign bus.instr_retired           = retired;
  assign bus.err                     = (state_q == S_ERR);

endmodule
